// File: rtl/i2c_write_master.sv
// I2C master issuing one 3-byte write (addr+W, register, data) per request.
// SCL is push-pull; SDA is open-drain and only ever pulled low.
module i2c_write_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic       nack,
    output logic [1:0] nack_byte,
    output logic       pin_scl,
    inout  wire        pin_sda
);

    localparam int QW = $clog2(CLK_DIV);
    localparam logic [QW-1:0] QMAX = QW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_ACK,
        S_STOP,
        S_DONE
    } state_t;

    state_t        state;
    logic [QW-1:0] qcnt;
    logic [1:0]    phase;
    logic [2:0]    bit_cnt;
    logic [1:0]    byte_idx;
    logic [6:0]    addr_q;
    logic [7:0]    reg_q;
    logic [7:0]    data_q;
    logic          sda_low;
    logic          tick;
    logic [7:0]    cur_byte;

    assign pin_sda = sda_low ? 1'b0 : 1'bz;
    assign tick    = busy && (qcnt == QMAX);

    always_comb begin
        unique case (byte_idx)
            2'd0:    cur_byte = {addr_q, 1'b0};
            2'd1:    cur_byte = reg_q;
            default: cur_byte = data_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qcnt <= '0;
        end else if (state == S_IDLE) begin
            qcnt <= '0;
        end else if (busy) begin
            qcnt <= tick ? '0 : qcnt + QW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            phase     <= 2'd0;
            bit_cnt   <= 3'd7;
            byte_idx  <= 2'd0;
            addr_q    <= '0;
            reg_q     <= '0;
            data_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            nack      <= 1'b0;
            nack_byte <= 2'd0;
            pin_scl   <= 1'b1;
            sda_low   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    // the done cycle itself never accepts a new request
                    if (start && !done) begin
                        addr_q    <= dev_addr;
                        reg_q     <= reg_addr;
                        data_q    <= wr_data;
                        nack      <= 1'b0;
                        nack_byte <= 2'd0;
                        busy      <= 1'b1;
                        phase     <= 2'd0;
                        bit_cnt   <= 3'd7;
                        byte_idx  <= 2'd0;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (phase == 2'd0) begin
                            sda_low <= 1'b1;
                            phase   <= 2'd1;
                        end else begin
                            phase <= 2'd0;
                            state <= S_BIT;
                        end
                    end
                end
                S_BIT: begin
                    if (tick) begin
                        phase <= phase + 2'd1;
                        unique case (phase)
                            2'd0: begin
                                pin_scl <= 1'b0;
                                sda_low <= ~cur_byte[bit_cnt];
                            end
                            2'd2: pin_scl <= 1'b1;
                            2'd3: begin
                                if (bit_cnt == 3'd0) begin
                                    state <= S_ACK;
                                end else begin
                                    bit_cnt <= bit_cnt - 3'd1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_ACK: begin
                    if (tick) begin
                        phase <= phase + 2'd1;
                        unique case (phase)
                            2'd0: begin
                                pin_scl <= 1'b0;
                                sda_low <= 1'b0;
                            end
                            2'd2: pin_scl <= 1'b1;
                            2'd3: begin
                                // a floating line counts as NACK
                                if (pin_sda == 1'b0) begin
                                    if (byte_idx == 2'd2) begin
                                        state <= S_STOP;
                                    end else begin
                                        byte_idx <= byte_idx + 2'd1;
                                        bit_cnt  <= 3'd7;
                                        state    <= S_BIT;
                                    end
                                end else begin
                                    nack      <= 1'b1;
                                    nack_byte <= byte_idx;
                                    state     <= S_STOP;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        unique case (phase)
                            2'd0: begin
                                pin_scl <= 1'b0;
                                sda_low <= 1'b1;
                                phase   <= 2'd1;
                            end
                            2'd1: begin
                                pin_scl <= 1'b1;
                                phase   <= 2'd2;
                            end
                            default: begin
                                sda_low <= 1'b0;
                                phase   <= 2'd0;
                                state   <= S_DONE;
                            end
                        endcase
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_write_master.sv
// Bench for i2c_write_master: behavioural slave on the bus, protocol monitor,
// and a transaction-level model of expected latency, status and received bytes.
module tb_i2c_write_master;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [6:0] dev_addr;
    logic [7:0] reg_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
    logic       nack;
    logic [1:0] nack_byte;
    logic       scl;
    wire        sda;
    logic       slave_low = 1'b0;

    assign sda = slave_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_write_master #(.CLK_DIV(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dev_addr  (dev_addr),
        .reg_addr  (reg_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .nack      (nack),
        .nack_byte (nack_byte),
        .pin_scl   (scl),
        .pin_sda   (sda)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Behavioural slave plus bus monitor, sampled mid-cycle
    logic [6:0] sl_addr = 7'h1A;
    logic [2:0] sl_mask = 3'b111;
    logic       ps = 1'b1, pd = 1'b1;
    logic       active = 1'b0, acking = 1'b0;
    int         bitn = 0, byten = 0;
    logic [7:0] sh = '0;
    logic [7:0] rx[$];
    int         st_cnt = 0, sp_cnt = 0, viol = 0, fall_cnt = 0;

    always @(negedge clk) begin
        ps <= scl;
        pd <= sda;
        if (ps && !scl) fall_cnt <= fall_cnt + 1;
        if (ps && scl && pd && !sda) begin
            st_cnt    <= st_cnt + 1;
            active    <= 1'b1;
            acking    <= 1'b0;
            bitn      <= 0;
            byten     <= 0;
            slave_low <= 1'b0;
        end else if (ps && scl && !pd && sda) begin
            sp_cnt    <= sp_cnt + 1;
            active    <= 1'b0;
            acking    <= 1'b0;
            slave_low <= 1'b0;
        end else if (ps && scl && (pd != sda)) begin
            viol <= viol + 1;
        end else if (active && !ps && scl && bitn < 8) begin
            sh   <= {sh[6:0], sda};
            bitn <= bitn + 1;
        end else if (active && ps && !scl) begin
            if (acking) begin
                acking    <= 1'b0;
                slave_low <= 1'b0;
                bitn      <= 0;
            end else if (bitn == 8) begin
                rx.push_back(sh);
                if (byten == 0 ? (sh == {sl_addr, 1'b0}) : sl_mask[byten]) begin
                    acking    <= 1'b1;
                    slave_low <= 1'b1;
                    byten     <= byten + 1;
                end else begin
                    active <= 1'b0;
                end
            end
        end
    end

    // Index of the first refused byte, 3 when all three are acknowledged
    function automatic int exp_k(input logic [6:0] a, input logic [6:0] sa,
                                 input logic [2:0] m);
        if (a != sa) return 0;
        for (int i = 1; i < 3; i++) if (!m[i]) return i;
        return 3;
    endfunction

    task automatic run_txn(input logic [6:0] a, input logic [7:0] r,
                           input logic [7:0] d, input string tag,
                           input bit b2b, input bit keep);
        int k, q, n, pulse_at, nb, rxb, s0, p0, v0, f0;
        logic [7:0] exp_b[3];
        k = exp_k(a, sl_addr, sl_mask);
        q = (k == 3) ? 113 : 2 + (k + 1) * 36 + 3;
        nb = (k == 3) ? 3 : k + 1;
        exp_b[0] = {a, 1'b0};
        exp_b[1] = r;
        exp_b[2] = d;
        rxb = rx.size();
        s0 = st_cnt;
        p0 = sp_cnt;
        v0 = viol;
        pulse_at = $urandom_range(5, q * D - 5);
        if (b2b) begin
            dev_addr = a; reg_addr = r; wr_data = d; start = 1'b1;
            @(posedge clk); #1;
            check({tag, ".ignored_busy"}, busy, 1'b0);
            check({tag, ".ignored_done"}, done, 1'b0);
            @(posedge clk); #1;
        end else begin
            @(negedge clk);
            dev_addr = a; reg_addr = r; wr_data = d; start = 1'b1;
            @(posedge clk); #1;
        end
        start = 1'b0;
        check({tag, ".accept_busy"}, busy, 1'b1);
        check({tag, ".accept_nack"}, nack, 1'b0);
        n = 0;
        while (!done && n < 2000) begin
            @(posedge clk); #1;
            n++;
            start = (n == pulse_at);
        end
        start = 1'b0;
        check({tag, ".latency"}, n, q * D + 1);
        check({tag, ".nack"}, nack, k != 3);
        check({tag, ".nack_byte"}, nack_byte, (k == 3) ? 0 : k);
        check({tag, ".busy_at_done"}, busy, 1'b0);
        check({tag, ".rx_count"}, rx.size() - rxb, nb);
        for (int i = 0; i < nb; i++)
            if (rxb + i < rx.size())
                check($sformatf("%s.rx%0d", tag, i), rx[rxb + i], exp_b[i]);
        check({tag, ".starts"}, st_cnt - s0, 1);
        check({tag, ".stops"}, sp_cnt - p0, 1);
        check({tag, ".sda_in_scl_high"}, viol - v0, 0);
        if (!keep) begin
            f0 = fall_cnt;
            repeat (30) @(posedge clk);
            #1;
            check({tag, ".idle_scl_pulses"}, fall_cnt - f0, 0);
            check({tag, ".idle_scl"}, scl, 1'b1);
            check({tag, ".idle_sda"}, sda, 1'b1);
        end
    endtask

    task automatic reset_mid();
        int n, dn;
        sl_addr = 7'h2C;
        sl_mask = 3'b111;
        @(negedge clk);
        dev_addr = 7'h2C; reg_addr = 8'hA5; wr_data = 8'h5A; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (n < 50 * D) begin
            @(posedge clk); #1;
            n++;
        end
        rst = 1'b1;
        #1;
        check("rstm.scl", scl, 1'b1);
        check("rstm.sda", sda, 1'b1);
        check("rstm.busy", busy, 1'b0);
        check("rstm.done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        repeat (600) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        check("rstm.no_done", dn, 0);
        run_txn(7'h2C, 8'hA5, 8'h5A, "post_rst", 1'b0, 1'b0);
    endtask

    initial begin
        bit kp_prev;
        rst = 1'b1; start = 1'b0;
        dev_addr = '0; reg_addr = '0; wr_data = '0;
        repeat (3) @(negedge clk);
        check("rst.busy", busy, 1'b0);
        check("rst.done", done, 1'b0);
        check("rst.nack", nack, 1'b0);
        check("rst.nack_byte", nack_byte, 2'd0);
        check("rst.scl", scl, 1'b1);
        check("rst.sda", sda, 1'b1);
        rst = 1'b0;

        sl_addr = 7'h1A; sl_mask = 3'b111;
        run_txn(7'h1A, 8'h75, 8'h74, "nominal", 1'b0, 1'b0);
        run_txn(7'h1B, 8'h75, 8'h74, "addr_nack", 1'b0, 1'b1);
        sl_mask = 3'b011;
        run_txn(7'h1A, 8'h33, 8'h44, "data_nack_b2b", 1'b1, 1'b0);
        reset_mid();

        kp_prev = 1'b0;
        for (int i = 0; i < 6; i++) begin
            int mode;
            bit kp;
            logic [6:0] a;
            mode = $urandom_range(0, 3);
            sl_addr = 7'($urandom);
            a = sl_addr;
            if (mode == 1) a = sl_addr ^ 7'($urandom_range(1, 127));
            sl_mask = (mode == 2) ? 3'b101 : (mode == 3) ? 3'b011 : 3'b111;
            kp = (i < 5) && ($urandom_range(0, 1) == 1);
            run_txn(a, 8'($urandom), 8'($urandom), $sformatf("rnd%0d", i),
                    kp_prev, kp);
            kp_prev = kp;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
